spi_burst_ctrl: RTL and testbench

Bus-master sequencer that sits directly upstream of the `spi_0` SPI master core and drives its register port, so firmware logic never has to. On a start pulse it clears the core's status, asserts the selected slave via the SSO bit, pushes N bytes from a valid/ready TX stream through the data-write register, and returns each received byte on a valid/ready RX stream. When the burst ends it releases SS_n and reports done, or error if the transfer timed out.

---
 rtl/spi_burst_ctrl.sv | 115 +++++++++++
 tb/tb_spi_burst_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_burst_ctrl.sv
// spi_burst_ctrl: sequences the spi_0 register port to run an N-byte burst
// with chip select held across the whole burst and a per-wait-state timeout.
module spi_burst_ctrl #(
    parameter int MAX_LEN = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [$clog2(MAX_LEN+1)-1:0] len,
    input  logic [15:0]                  slave_mask,
    input  logic [7:0]                   tx_data,
    input  logic                         tx_valid,
    output logic                         tx_ready,
    output logic [7:0]                   rx_data,
    output logic                         rx_valid,
    input  logic                         rx_ready,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic                         spi_select,
    output logic [2:0]                   spi_addr,
    output logic [15:0]                  spi_wdata,
    output logic                         spi_read_n,
    output logic                         spi_write_n,
    input  logic [15:0]                  spi_rdata,
    input  logic                         spi_trdy,
    input  logic                         spi_rrdy
);
    localparam int LW = $clog2(MAX_LEN+1);
    localparam int TW = $clog2(TIMEOUT+1);

    typedef enum logic [3:0] {IDLE, CLR, SEL, SSON, WTX, WR, WRX, RD, PUSH, SSOFF, DONE} state_t;

    state_t st, nxt;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [LW-1:0] cnt;
    logic [15:0] mask, wdata_n;
    logic [2:0] addr_n;
    logic go, last, tmo, acc, stb;
    logic rdata_unused;

    assign rdata_unused = ^spi_rdata[15:8];
    assign go = st == IDLE && start;
    assign last = tcnt == TW'(2);
    assign tmo = tcnt == TW'(TIMEOUT) && ((st == WTX && !(tx_valid && spi_trdy)) ||
                 (st == WRX && !spi_rrdy) || (st == PUSH && !rx_ready));

    always_comb begin
        nxt = st;
        case (st)
            IDLE:    nxt = start ? CLR : IDLE;
            CLR:     nxt = last ? SEL : CLR;
            SEL:     nxt = last ? SSON : SEL;
            SSON:    nxt = !last ? SSON : cnt == '0 ? SSOFF : WTX;
            WTX:     nxt = tx_valid && spi_trdy ? WR : tmo ? SSOFF : WTX;
            WR:      nxt = last ? WRX : WR;
            WRX:     nxt = spi_rrdy ? RD : tmo ? SSOFF : WRX;
            RD:      nxt = last ? PUSH : RD;
            PUSH:    nxt = rx_ready ? (cnt == LW'(1) ? SSOFF : WTX) : tmo ? SSOFF : PUSH;
            SSOFF:   nxt = last ? DONE : SSOFF;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // The dwell counter doubles as the access phase: 0,1 strobe, 2 bus gap.
    assign tcnt_n = (nxt != st || st == IDLE) ? '0 : tcnt + 1'b1;
    assign acc = nxt inside {CLR, SEL, SSON, WR, RD, SSOFF};
    assign stb = acc && tcnt_n != TW'(2);

    always_comb begin
        addr_n = nxt == CLR ? 3'd2 : nxt == SEL ? 3'd5 :
                 (nxt == SSON || nxt == SSOFF) ? 3'd3 : nxt == WR ? 3'd1 : 3'd0;
        wdata_n = nxt == SEL ? mask : nxt == SSON ? 16'h0400 :
                  nxt == WR ? (st == WR ? spi_wdata : {8'h00, tx_data}) : 16'h0000;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st <= IDLE;
            tcnt <= '0;
            cnt <= '0;
            mask <= '0;
            err <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            rx_data <= '0;
            spi_select <= 1'b0;
            spi_read_n <= 1'b1;
            spi_write_n <= 1'b1;
            spi_addr <= '0;
            spi_wdata <= '0;
        end else begin
            st <= nxt;
            tcnt <= tcnt_n;
            cnt <= go ? (len > LW'(MAX_LEN) ? LW'(MAX_LEN) : len) :
                   (st == PUSH && rx_ready) ? cnt - 1'b1 : cnt;
            mask <= go ? slave_mask : mask;
            err <= go ? 1'b0 : err | tmo;
            busy <= nxt != IDLE && nxt != DONE;
            done <= nxt == DONE;
            tx_ready <= nxt == WR && st != WR;
            rx_valid <= nxt == PUSH;
            rx_data <= (st == RD && tcnt == TW'(1)) ? spi_rdata[7:0] : rx_data;
            spi_select <= stb;
            spi_write_n <= !(stb && nxt != RD);
            spi_read_n <= !(stb && nxt == RD);
            spi_addr <= addr_n;
            spi_wdata <= wdata_n;
        end
    end
endmodule

// File: tb/tb_spi_burst_ctrl.sv
// tb_spi_burst_ctrl: table-driven bursts against a loopback spi_0 register model,
// plus hand-written reset-value and mid-burst reset sequences.
module tb_spi_burst_ctrl;
    logic clk = 1'b0;
    logic reset, start, tx_valid, rx_ready;
    logic [5:0] len;
    logic [15:0] slave_mask;
    logic [7:0] tx_data;
    logic tx_ready, rx_valid, busy, done, err;
    logic [7:0] rx_data;
    logic spi_select, spi_read_n, spi_write_n;
    logic [2:0] spi_addr;
    logic [15:0] spi_wdata;
    logic [15:0] spi_rdata = 16'h0000;
    logic spi_trdy = 1'b1;
    logic spi_rrdy = 1'b0;

    spi_burst_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .slave_mask(slave_mask),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .busy(busy), .done(done), .err(err),
        .spi_select(spi_select), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
        .spi_read_n(spi_read_n), .spi_write_n(spi_write_n),
        .spi_rdata(spi_rdata), .spi_trdy(spi_trdy), .spi_rrdy(spi_rrdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;
        logic [15:0] mask;
        logic [7:0] base;
        int hold;
        bit txen;
        bit restart;
        int exp_bytes;
        bit exp_err;
        int exp_busy;
        int exp_txr;
    } rec_t;

    localparam logic [34:0] RST_V = {1'b0, 1'b1, 1'b1, 3'd0, 16'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};

    int passed = 0, total = 0;
    int proto_err = 0, ss_viol = 0, run = 0, rdly = 0, rr_delay = 4;
    logic ss_on = 1'b0;
    logic [2:0] a0;
    logic [15:0] d0;
    logic r0;
    logic [2:0] la[$];
    logic [15:0] ld[$];
    bit lr[$];
    rec_t tbl[6];

    function automatic logic [34:0] outs();
        return {spi_select, spi_read_n, spi_write_n, spi_addr, spi_wdata,
                tx_ready, rx_valid, rx_data, busy, done, err};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Loopback register model of spi_0 plus a bus-protocol monitor.
    always @(posedge clk) begin
        if (reset) begin
            spi_trdy <= 1'b1;
            spi_rrdy <= 1'b0;
            rdly <= 0;
            ss_on <= 1'b0;
            run = 0;
        end else begin
            if (rdly > 1) rdly <= rdly - 1;
            else if (rdly == 1) begin
                rdly <= 0;
                spi_rrdy <= 1'b1;
            end
            if (spi_select) begin
                if (run == 0) begin
                    a0 = spi_addr;
                    d0 = spi_wdata;
                    r0 = !spi_read_n;
                    la.push_back(a0);
                    ld.push_back(d0);
                    lr.push_back(r0);
                    if ((a0 == 3'd0 || a0 == 3'd1) && !ss_on) ss_viol++;
                    if (r0 && a0 == 3'd0) begin
                        spi_rrdy <= 1'b0;
                        spi_trdy <= 1'b1;
                    end
                    if (!r0) begin
                        case (a0)
                            3'd1: begin
                                spi_rdata <= {8'hEE, d0[7:0]};
                                spi_trdy <= 1'b0;
                                rdly <= rr_delay;
                            end
                            3'd2: begin
                                spi_rrdy <= 1'b0;
                                spi_trdy <= 1'b1;
                            end
                            3'd3: ss_on <= d0[10];
                            default: ;
                        endcase
                    end
                end else if (spi_addr != a0 || spi_wdata != d0 || !spi_read_n != r0) proto_err++;
                if (spi_read_n == spi_write_n) proto_err++;
                run++;
            end else begin
                if (run != 0 && run != 2) proto_err++;
                if (!spi_read_n || !spi_write_n) proto_err++;
                run = 0;
            end
        end
    end

    task automatic burst(input int ri, input rec_t r);
        int idx = 0, w = 0, end_at = 0, done_cnt = 0, txr = 0, busy_cyc = 0, t_txr = -1, mism;
        int p0 = proto_err, v0 = ss_viol;
        logic [6:0] s1 = '0;
        logic [7:0] rxq[$];
        logic [2:0] ea[$];
        logic [15:0] ed[$];
        bit er[$];
        string t = $sformatf("r%0d_", ri);
        la.delete(); ld.delete(); lr.delete();
        @(negedge clk);
        len = 6'(r.n);
        slave_mask = r.mask;
        tx_valid = r.txen;
        tx_data = r.base;
        rx_ready = 1'b0;
        start = 1'b1;
        for (int cyc = 1; cyc <= 3000 && (end_at == 0 || cyc < end_at); cyc++) begin
            @(negedge clk);
            start = r.restart && cyc == 20;
            if (cyc == 1) s1 = {busy, err, spi_select, spi_addr, spi_write_n};
            if (busy) busy_cyc++;
            if (tx_ready) begin
                txr++;
                if (t_txr < 0) t_txr = cyc;
                idx++;
                tx_data = 8'(r.base + idx);
            end
            if (rx_valid && w >= r.hold) begin
                rx_ready = 1'b1;
                rxq.push_back(rx_data);
            end else rx_ready = 1'b0;
            w = rx_valid ? w + 1 : 0;
            if (done) begin
                done_cnt++;
                if (end_at == 0) end_at = cyc + 4;
            end
        end
        start = 1'b0;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        chk({t, "start_cycle1"}, s1, 7'b1_0_1_010_0);
        chk({t, "done_count"}, done_cnt, 1);
        chk({t, "err"}, err, r.exp_err);
        chk({t, "busy_after"}, busy, 0);
        chk({t, "tx_ready_count"}, txr, r.exp_bytes);
        chk({t, "rx_count"}, rxq.size(), r.exp_bytes);
        mism = 0;
        for (int i = 0; i < rxq.size() && i < r.exp_bytes; i++)
            if (rxq[i] !== 8'(r.base + i)) mism++;
        chk({t, "rx_data"}, mism, 0);
        ea = '{3'd2, 3'd5, 3'd3};
        ed = '{16'h0, r.mask, 16'h0400};
        er = '{0, 0, 0};
        for (int i = 0; i < r.exp_bytes; i++) begin
            ea.push_back(3'd1); ed.push_back({8'h00, 8'(r.base + i)}); er.push_back(0);
            ea.push_back(3'd0); ed.push_back(16'h0); er.push_back(1);
        end
        ea.push_back(3'd3); ed.push_back(16'h0000); er.push_back(0);
        chk({t, "access_count"}, la.size(), ea.size());
        mism = 0;
        for (int i = 0; i < la.size() && i < ea.size(); i++)
            if (la[i] != ea[i] || lr[i] != er[i] || (ea[i] != 3'd2 && !er[i] && ld[i] != ed[i])) mism++;
        chk({t, "access_order"}, mism, 0);
        chk({t, "bus_protocol"}, proto_err - p0, 0);
        chk({t, "ss_held"}, ss_viol - v0, 0);
        if (r.exp_busy >= 0) chk({t, "busy_cycles"}, busy_cyc, r.exp_busy);
        if (r.exp_txr >= 0) chk({t, "first_tx_ready_cycle"}, t_txr, r.exp_txr);
    endtask

    initial begin
        int seen;
        rec_t clean;
        reset = 1'b1; start = 1'b0; len = '0; slave_mask = '0;
        tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_values", outs(), RST_V);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_values", outs(), RST_V);

        tbl[0] = '{1, 16'h0001, 8'hA5, 0, 1'b1, 1'b0, 1, 1'b0, -1, 11};
        tbl[1] = '{4, 16'h0003, 8'h01, 20, 1'b1, 1'b0, 4, 1'b0, -1, 11};
        tbl[2] = '{0, 16'h0002, 8'h00, 0, 1'b1, 1'b0, 0, 1'b0, 12, -1};
        tbl[3] = '{2, 16'h0004, 8'h10, 0, 1'b0, 1'b0, 0, 1'b1, -1, -1};
        tbl[4] = '{40, 16'hFFFF, 8'h40, 1, 1'b1, 1'b1, 32, 1'b0, -1, 11};
        tbl[5] = '{3, 16'h8000, 8'hF0, 3, 1'b1, 1'b0, 3, 1'b0, -1, 11};
        for (int i = 0; i < 6; i++) burst(i, tbl[i]);

        // Reset while waiting for the second of three received bytes.
        rr_delay = 30;
        @(negedge clk);
        len = 6'd3; slave_mask = 16'h0020; tx_data = 8'h3C; tx_valid = 1'b1; rx_ready = 1'b1;
        start = 1'b1;
        seen = 0;
        for (int c = 0; c < 400 && seen < 2; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (tx_ready) seen++;
        end
        chk("mid_second_byte_reached", seen, 2);
        repeat (3) @(negedge clk);
        chk("mid_in_wrx", {busy, spi_select, rx_valid, rx_data}, {1'b1, 1'b0, 1'b0, 8'h3C});
        reset = 1'b1;
        #1;
        chk("mid_reset_values", outs(), RST_V);
        tx_valid = 1'b0; rx_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rr_delay = 4;
        clean = '{2, 16'h0010, 8'h77, 2, 1'b1, 1'b0, 2, 1'b0, -1, 11};
        burst(9, clean);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
